// File: rtl/fft_frame_source.sv
// fft_frame_source
//   Source-side framer for a streaming FFT core. Upstream samples arrive on a
//   ready/valid stream and are written into one of two ping-pong frame banks.
//   Each full bank is replayed to the FFT sink as FFT_LEN back-to-back valid
//   beats with a constant channel tag. A frame closed early by s_last is
//   zero-padded up to FFT_LEN before it is handed to the reader.
//
// Ports
//   clk, rst      single clock, synchronous active-high reset
//   s_valid       upstream sample valid
//   s_ready       upstream may transfer when s_valid & s_ready
//   s_data        upstream sample (re [63:32], im [31:0] at DATA_W=64)
//   s_channel     channel tag, captured on the first beat of each frame
//   s_last        final sample of a (possibly short) frame
//   fft_valid     FFT validIn
//   fft_channel   FFT channelIn, constant over a frame
//   fft_d         FFT data, zero whenever fft_valid is low
//   frames_out    frames fully emitted, wraps
//   pad_events    frames closed short by s_last, saturates at all-ones
module fft_frame_source #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 64,
  parameter int CHAN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CHAN_W-1:0] s_channel,
  input  logic              s_last,
  output logic              fft_valid,
  output logic [CHAN_W-1:0] fft_channel,
  output logic [DATA_W-1:0] fft_d,
  output logic [31:0]       frames_out,
  output logic [15:0]       pad_events
);

  localparam int AW = $clog2(FFT_LEN);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_PAD} wstate_t;
  typedef enum logic {R_IDLE, R_BURST} rstate_t;

  // write side
  wstate_t           w_state_reg, w_state_next;
  logic [AW-1:0]     wa_reg, wa_next;
  logic              wb_reg, wb_next;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              chan_we;
  logic              set_full;
  logic              pad_inc;

  // read side
  rstate_t           r_state_reg, r_state_next;
  logic [AW-1:0]     ra_reg, ra_next;
  logic              rb_reg, rb_next;
  logic              rd_en;
  logic              clr_full;

  logic [1:0]        bank_full_reg, bank_full_next;
  logic [CHAN_W-1:0] chan_reg [0:1];

  logic [DATA_W-1:0] mem [0:2*FFT_LEN-1];
  logic [DATA_W-1:0] rd_data_reg;

  logic              fft_valid_reg;
  logic [CHAN_W-1:0] fft_channel_reg;
  logic              done_reg;
  logic [31:0]       frames_out_reg;
  logic [15:0]       pad_events_reg;

  // ---------------------------------------------------------------- write FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_reg <= W_IDLE;
      wa_reg      <= '0;
      wb_reg      <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      wa_reg      <= wa_next;
      wb_reg      <= wb_next;
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    wa_next      = wa_reg;
    wb_next      = wb_reg;
    s_ready      = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = s_data;
    chan_we      = 1'b0;
    set_full     = 1'b0;
    pad_inc      = 1'b0;
    case (w_state_reg)
      // one idle cycle out of reset keeps s_ready low until the first
      // edge after rst deasserts
      W_IDLE: w_state_next = W_FILL;
      W_FILL: begin
        s_ready = !bank_full_reg[wb_reg];
        if (s_valid && s_ready) begin
          mem_we  = 1'b1;
          chan_we = (wa_reg == '0);
          if (wa_reg == LAST_ADDR) begin
            // a full-length frame: s_last here (if any) is not a pad event
            set_full = 1'b1;
            wb_next  = ~wb_reg;
            wa_next  = '0;
          end else begin
            wa_next = wa_reg + 1'b1;
            if (s_last) begin
              pad_inc      = 1'b1;
              w_state_next = W_PAD;
            end
          end
        end
      end
      W_PAD: begin
        // the bank being padded is never full, so no ready check is needed
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (wa_reg == LAST_ADDR) begin
          set_full     = 1'b1;
          wb_next      = ~wb_reg;
          wa_next      = '0;
          w_state_next = W_FILL;
        end else begin
          wa_next = wa_reg + 1'b1;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- read FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_reg <= R_IDLE;
      ra_reg      <= '0;
      rb_reg      <= 1'b0;
    end else begin
      r_state_reg <= r_state_next;
      ra_reg      <= ra_next;
      rb_reg      <= rb_next;
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    ra_next      = ra_reg;
    rb_next      = rb_reg;
    rd_en        = 1'b0;
    clr_full     = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        if (bank_full_reg[rb_reg]) begin
          r_state_next = R_BURST;
          ra_next      = '0;
        end
      end
      R_BURST: begin
        rd_en = 1'b1;
        if (ra_reg == LAST_ADDR) begin
          clr_full = 1'b1;
          rb_next  = ~rb_reg;
          ra_next  = '0;
          // chain straight into the other bank for a gapless hand-off
          if (!bank_full_reg[~rb_reg]) r_state_next = R_IDLE;
        end else begin
          ra_next = ra_reg + 1'b1;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // --------------------------------------------------------------- bank flags
  // The writer only sets a bank it is filling (not full) and the reader only
  // clears a full one, so a set and clear never hit the same bit.
  always_comb begin
    bank_full_next = bank_full_reg;
    if (set_full) bank_full_next[wb_reg] = 1'b1;
    if (clr_full) bank_full_next[rb_reg] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) bank_full_reg <= 2'b00;
    else     bank_full_reg <= bank_full_next;
  end

  // per-bank channel tag, latched on the first beat of the frame
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (rst)                                chan_reg[gi] <= '0;
        else if (chan_we && (wb_reg == 1'(gi))) chan_reg[gi] <= s_channel;
      end
    end
  endgenerate

  // ------------------------------------------------------------ frame storage
  // Banks are address-disjoint ({bank, addr}); the reader never touches the
  // bank being written, so there is no read/write collision to resolve.
  always_ff @(posedge clk) begin
    if (mem_we) mem[{wb_reg, wa_reg}] <= mem_wdata;
    if (rd_en)  rd_data_reg <= mem[{rb_reg, ra_reg}];
  end

  // ------------------------------------------------------- output and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fft_valid_reg   <= 1'b0;
      fft_channel_reg <= '0;
      done_reg        <= 1'b0;
      frames_out_reg  <= '0;
      pad_events_reg  <= '0;
    end else begin
      fft_valid_reg <= rd_en;
      if (rd_en) fft_channel_reg <= chan_reg[rb_reg];
      // frame counted one edge after its last address issue, i.e. as the
      // final beat leaves the output register
      done_reg <= clr_full;
      if (done_reg) frames_out_reg <= frames_out_reg + 32'd1;
      if (pad_inc && (pad_events_reg != 16'hFFFF))
        pad_events_reg <= pad_events_reg + 16'd1;
    end
  end

  // the read register is left unreset; masking keeps fft_d at zero between frames
  assign fft_valid   = fft_valid_reg;
  assign fft_d       = fft_valid_reg ? rd_data_reg : '0;
  assign fft_channel = fft_channel_reg;
  assign frames_out  = frames_out_reg;
  assign pad_events  = pad_events_reg;

endmodule

// File: tb/tb_fft_frame_source.sv
`timescale 1ns/1ps
module tb_fft_frame_source;
  localparam int FFT_LEN = 1024;
  localparam int DATA_W  = 64;
  localparam int CHAN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [CHAN_W-1:0] s_channel = '0;
  logic              s_last = 1'b0;
  logic              fft_valid;
  logic [CHAN_W-1:0] fft_channel;
  logic [DATA_W-1:0] fft_d;
  logic [31:0]       frames_out;
  logic [15:0]       pad_events;

  always #5 clk = ~clk;

  fft_frame_source #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W), .CHAN_W(CHAN_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_channel(s_channel), .s_last(s_last),
    .fft_valid(fft_valid), .fft_channel(fft_channel), .fft_d(fft_d),
    .frames_out(frames_out), .pad_events(pad_events)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: {channel, data} per expected output beat
  logic [CHAN_W+DATA_W-1:0] exp_q [$];
  logic [CHAN_W+DATA_W-1:0] e;
  int              cur_n = 0;
  logic [CHAN_W-1:0] cur_chan = '0;
  int              exp_frames = 0;
  int              exp_pads = 0;

  int   cyc = 0;
  int   beat_idx = 0;
  logic prev_valid = 1'b0;
  int   rise_cyc = 0;
  int   rises = 0;
  logic mon_en = 1'b0;
  int   last_acc = 0;
  int   stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model_beat(input logic [DATA_W-1:0] d, input logic [CHAN_W-1:0] c,
                                     input logic l);
    if (cur_n == 0) cur_chan = c;
    exp_q.push_back({cur_chan, d});
    cur_n++;
    if (cur_n == FFT_LEN) begin
      cur_n = 0;
      exp_frames++;
    end else if (l) begin
      while (cur_n < FFT_LEN) begin
        exp_q.push_back({cur_chan, {DATA_W{1'b0}}});
        cur_n++;
      end
      cur_n = 0;
      exp_frames++;
      exp_pads++;
    end
  endfunction

  // output monitor: pops the scoreboard on every valid beat
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        beat_idx   = 0;
        prev_valid = 1'b0;
      end else begin
        if (fft_valid) begin
          if (!prev_valid) begin
            rise_cyc = cyc;
            rises++;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", fft_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", fft_d, e[DATA_W-1:0]);
            chk("beat_chan", fft_channel, e[CHAN_W+DATA_W-1:DATA_W]);
          end
          beat_idx = (beat_idx + 1) % FFT_LEN;
        end else begin
          chk("idle_d_zero", fft_d, 0);
          if (prev_valid) chk("frame_contiguous", beat_idx, 0);
        end
        prev_valid = fft_valid;
      end
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    cur_n = 0; exp_frames = 0; exp_pads = 0;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_fft_valid", fft_valid, 0);
    chk("rst_fft_d", fft_d, 0);
    chk("rst_fft_channel", fft_channel, 0);
    chk("rst_frames_out", frames_out, 0);
    chk("rst_pad_events", pad_events, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("s_ready_after_rst", s_ready, 1);
    mon_en = 1'b1;
    rises = 0;
    stall_cnt = 0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [CHAN_W-1:0] c, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_channel = c; s_last = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      stall_cnt++;
      n++;
      if (n > 5000) break;
    end
    if (n > 5000) begin
      chk("s_ready_timeout", s_ready, 1);
      s_valid = 1'b0;
    end else begin
      model_beat(d, c, l);
      @(posedge clk); #1;
      last_acc = cyc;
    end
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    while ((exp_q.size() != 0 || fft_valid) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, (n < 20000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int pad_low;
    int n;
    int len;
    logic short_f;
    logic [CHAN_W-1:0] ch;

    // 1: one full frame, latency and contents
    do_reset();
    for (int i = 0; i < FFT_LEN; i++) send_beat(64'(i), 8'd5, 1'b0);
    wait_drain("t1");
    chk("t1_latency", rise_cyc, last_acc + 2);
    chk("t1_rises", rises, 1);
    chk("t1_frames_out", frames_out, 1);
    $display("t1 single frame: frames_out=%0d rise_cyc=%0d last_acc=%0d", frames_out, rise_cyc, last_acc);

    // 2: three frames back to back
    do_reset();
    for (int f = 1; f <= 3; f++)
      for (int i = 0; i < FFT_LEN; i++) send_beat({32'(f), 32'(i)}, 8'(f), 1'b0);
    wait_drain("t2");
    chk("t2_s_ready_dropped", (stall_cnt > 0), 1);
    chk("t2_gapless_1_2", rises, 2);
    chk("t2_frames_out", frames_out, 3);
    $display("t2 three frames: frames_out=%0d stalls=%0d bursts=%0d", frames_out, stall_cnt, rises);

    // 3: short frame padded with zeros
    do_reset();
    for (int i = 0; i < 10; i++) send_beat(64'(100 + i), 8'd7, (i == 9));
    s_valid = 1'b0;
    s_last  = 1'b0;
    pad_low = 0;
    repeat (1100) begin
      @(negedge clk);
      if (!s_ready) pad_low++;
    end
    chk("t3_pad_cycles", pad_low, 1014);
    wait_drain("t3");
    chk("t3_pad_events", pad_events, 1);
    chk("t3_frames_out", frames_out, 1);
    $display("t3 short frame: pad_cycles=%0d pad_events=%0d", pad_low, pad_events);

    // 4: s_last on the final beat is not a pad; next beat opens frame 2
    do_reset();
    for (int i = 0; i < FFT_LEN; i++) send_beat(64'(i * 3), 8'h11, (i == FFT_LEN - 1));
    for (int i = 0; i < FFT_LEN; i++) send_beat(64'(i * 5 + 1), 8'h22, 1'b0);
    wait_drain("t4");
    chk("t4_pad_events", pad_events, 0);
    chk("t4_frames_out", frames_out, 2);
    $display("t4 last on beat 1024: pad_events=%0d frames_out=%0d", pad_events, frames_out);

    // 5: reset mid-burst and mid-fill, then a clean frame
    do_reset();
    for (int i = 0; i < FFT_LEN; i++) send_beat({$urandom, $urandom}, 8'd9, 1'b0);
    for (int i = 0; i < 400; i++) send_beat({$urandom, $urandom}, 8'd10, 1'b0);
    s_valid = 1'b0;
    n = 0;
    while (beat_idx < 500 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_mid_burst", (n < 3000), 1);
    chk("t5_valid_mid_burst", fft_valid, 1);
    @(posedge clk); #1;
    do_reset();
    chk("t5_valid_after_rst", fft_valid, 0);
    for (int i = 0; i < FFT_LEN; i++) send_beat({$urandom, $urandom}, 8'd4, 1'b0);
    wait_drain("t5");
    chk("t5_frames_out", frames_out, 1);
    $display("t5 reset mid-burst: frames_out=%0d", frames_out);

    // 6: random bubbles, random short frames
    do_reset();
    for (int f = 0; f < 20; f++) begin
      ch      = 8'($urandom);
      short_f = ($urandom_range(0, 3) == 0);
      len     = short_f ? int'($urandom_range(1, FFT_LEN - 1)) : FFT_LEN;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 1) == 1) idle_cycle();
        send_beat({$urandom, $urandom}, ch,
                  (i == len - 1) && (short_f || ($urandom_range(0, 1) == 1)));
      end
    end
    wait_drain("t6");
    chk("t6_frames_out", frames_out, exp_frames);
    chk("t6_pad_events", pad_events, exp_pads);
    $display("t6 random: frames_out=%0d pad_events=%0d expected %0d/%0d",
             frames_out, pad_events, exp_frames, exp_pads);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
